// File: rtl/mips_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mips_pkg: constants and next-PC select encoding shared by pipeline stages.
// Revision: 1.0
// ----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_JUMP   = 2'd2,
    NPC_HOLD   = 2'd3
  } npc_sel_e;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// if_id_reg: IF/ID pipeline register with hold and flush (bubble) controls.
// Revision: 1.0
// ----------------------------------------------------------------------------
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_hold,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc_plus4;
  logic        r_valid;

  // Flush keeps pc_plus4 so a bubble still carries its last known link value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_WORD;
      r_pc_plus4 <= 32'h0;
      r_valid    <= 1'b0;
    end else if (i_flush) begin
      r_instr    <= NOP_WORD;
      r_valid    <= 1'b0;
    end else if (!i_hold) begin
      r_instr    <= i_instr;
      r_pc_plus4 <= i_pc_plus4;
      r_valid    <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_stage: MIPS IF stage - PC, next-PC select, fetch-fault check, IF/ID.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = mips_pkg::DEFAULT_RESET_PC,
  parameter int          IMEM_BYTES = 256,
  parameter logic [31:0] NOP_WORD   = mips_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] read_address,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  import mips_pkg::*;

  localparam logic [31:0] c_MAX_PC = 32'(IMEM_BYTES - 4);

  logic [31:0] r_pc;
  logic        r_fault;
  logic [31:0] r_count;

  npc_sel_e    w_sel;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_illegal;
  logic        w_seq_fault;
  logic        w_fetch_ok;
  logic        w_flush;
  logic        w_hold;

  // Branch outranks stall (older instruction); a stalled jump is re-presented.
  always_comb begin
    w_sel = NPC_SEQ;
    if (branch_taken)       w_sel = NPC_BRANCH;
    else if (jump && !stall) w_sel = NPC_JUMP;
    else if (stall)          w_sel = NPC_HOLD;
  end

  always_comb begin
    w_pc_next = r_pc;
    case (w_sel)
      NPC_BRANCH: w_pc_next = branch_target;
      NPC_JUMP:   w_pc_next = jump_target;
      NPC_HOLD:   w_pc_next = r_pc;
      default:    w_pc_next = w_pc_plus4;
    endcase
  end

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_illegal   = (r_pc[1:0] != 2'b00) || (r_pc > c_MAX_PC);
  assign w_seq_fault = (w_sel == NPC_SEQ) && w_illegal;
  assign w_fetch_ok  = (w_sel == NPC_SEQ) && !w_illegal;
  assign w_flush     = (w_sel == NPC_BRANCH) || (w_sel == NPC_JUMP) || w_seq_fault;
  assign w_hold      = (w_sel == NPC_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= RESET_PC;
      r_fault <= 1'b0;
      r_count <= 32'h0;
    end else begin
      r_pc    <= w_pc_next;
      r_fault <= r_fault | w_seq_fault;
      if (w_fetch_ok) r_count <= r_count + 32'd1;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hold     (w_hold),
    .i_flush    (w_flush),
    .i_instr    (instruction),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (if_id_instr),
    .o_pc_plus4 (if_id_pc_plus4),
    .o_valid    (if_id_valid)
  );

  assign read_address = r_pc;
  assign pc           = r_pc;
  assign fetch_fault  = r_fault;
  assign fetch_count  = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fetch_stage: scoreboard bench for fetch_stage against a big-endian ROM.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] read_address;
  logic [31:0] instruction;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] mem [256];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  exp_t sbq[$];

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_fault;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (32'h0),
    .IMEM_BYTES (256),
    .NOP_WORD   (32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_address   (read_address),
    .instruction    (instruction),
    .stall          (stall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_target    (jump_target),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {mem[b], mem[b + 8'd1], mem[b + 8'd2], mem[b + 8'd3]};
  endfunction

  always_comb instruction = memword(read_address);

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_cnt = 32'h0;
    m_valid = 1'b0; m_fault = 1'b0;
    sbq.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one cycle, predicts the post-edge state, compares after the edge.
  task automatic drive_and_score(input logic st, input logic br, input logic [31:0] bt,
                                 input logic jp, input logic [31:0] jt);
    exp_t e;
    logic [31:0] word;
    logic        bad;
    word = memword(m_pc);
    bad  = (m_pc[1:0] != 2'b00) || (m_pc > 32'd252);
    if (br) begin
      m_pc = bt; m_instr = 32'h0; m_valid = 1'b0;
    end else if (jp && !st) begin
      m_pc = jt; m_instr = 32'h0; m_valid = 1'b0;
    end else if (!st) begin
      if (bad) begin
        m_fault = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
      m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
    e.valid = m_valid; e.fault = m_fault; e.cnt = m_cnt;
    sbq.push_back(e);
    stall = st; branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    @(posedge clk);
    #1;
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    e = sbq.pop_front();
    n_vec++;
    if (pc !== e.pc || read_address !== e.pc) begin
      n_err++; $display("FAIL sb_pc: got pc=%h ra=%h expected %h", pc, read_address, e.pc);
    end
    n_vec++;
    if (if_id_instr !== e.instr || if_id_valid !== e.valid) begin
      n_err++; $display("FAIL sb_ifid: got instr=%h valid=%b expected instr=%h valid=%b",
                        if_id_instr, if_id_valid, e.instr, e.valid);
    end
    n_vec++;
    if (if_id_pc_plus4 !== e.pc4) begin
      n_err++; $display("FAIL sb_pc4: got %h expected %h", if_id_pc_plus4, e.pc4);
    end
    n_vec++;
    if (fetch_fault !== e.fault || fetch_count !== e.cnt) begin
      n_err++; $display("FAIL sb_fault_cnt: got fault=%b cnt=%0d expected fault=%b cnt=%0d",
                        fetch_fault, fetch_count, e.fault, e.cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    n_vec++;
    if (pc !== 32'h0 || if_id_instr !== 32'h0 || if_id_pc_plus4 !== 32'h0 ||
        if_id_valid !== 1'b0 || fetch_fault !== 1'b0 || fetch_count !== 32'h0) begin
      n_err++; $display("FAIL reset_values: pc=%h instr=%h pc4=%h v=%b f=%b cnt=%0d expected all zero",
                        pc, if_id_instr, if_id_pc_plus4, if_id_valid, fetch_fault, fetch_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    n_vec++;
    if (pc !== 32'h0 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: pc=%h valid=%b expected 0/0", pc, if_id_valid);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 3; i++) drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (pc !== 32'd12 || if_id_instr !== 32'h0109_5020 || if_id_pc_plus4 !== 32'd12 ||
        fetch_count !== 32'd3) begin
      n_err++; $display("FAIL seq_3: pc=%h instr=%h pc4=%h cnt=%0d expected c/01095020/c/3",
                        pc, if_id_instr, if_id_pc_plus4, fetch_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drive_and_score(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    drive_and_score(1'b1, 1'b0, 32'h0, 1'b1, 32'h80);
    n_vec++;
    if (pc !== 32'd8 || if_id_instr !== 32'h2009_0007 || if_id_pc_plus4 !== 32'd8 ||
        fetch_count !== 32'd2) begin
      n_err++; $display("FAIL stall_hold: pc=%h instr=%h pc4=%h cnt=%0d expected 8/20090007/8/2",
                        pc, if_id_instr, if_id_pc_plus4, fetch_count);
    end
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (pc !== 32'd12 || if_id_instr !== 32'h0109_5020 || fetch_count !== 32'd3) begin
      n_err++; $display("FAIL stall_release: pc=%h instr=%h cnt=%0d expected c/01095020/3",
                        pc, if_id_instr, fetch_count);
    end
  endtask

  task automatic test_redirect();
    drive_and_score(1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    n_vec++;
    if (pc !== 32'd64 || if_id_valid !== 1'b0 || if_id_instr !== 32'h0) begin
      n_err++; $display("FAIL branch_in_stall: pc=%h valid=%b instr=%h expected 40/0/0",
                        pc, if_id_valid, if_id_instr);
    end
    drive_and_score(1'b0, 1'b1, 32'h20, 1'b1, 32'h80);
    n_vec++;
    if (pc !== 32'd32) begin
      n_err++; $display("FAIL branch_beats_jump: pc=%h expected 20", pc);
    end
  endtask

  task automatic test_jump_fault();
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b1, 32'h102);
    n_vec++;
    if (pc !== 32'h102 || fetch_fault !== 1'b0) begin
      n_err++; $display("FAIL jump_load: pc=%h fault=%b expected 102/0", pc, fetch_fault);
    end
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (pc !== 32'h106 || fetch_fault !== 1'b1 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL fault_set: pc=%h fault=%b valid=%b expected 106/1/0",
                        pc, fetch_fault, if_id_valid);
    end
    drive_and_score(1'b0, 1'b1, 32'h0, 1'b0, 32'h0);
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (fetch_fault !== 1'b1 || if_id_valid !== 1'b1) begin
      n_err++; $display("FAIL fault_sticky: fault=%b valid=%b expected 1/1", fetch_fault, if_id_valid);
    end
    do_reset();
    #1;
    n_vec++;
    if (fetch_fault !== 1'b0) begin
      n_err++; $display("FAIL fault_clear: fault=%b expected 0", fetch_fault);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b1, 32'hFC);
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (fetch_fault !== 1'b0 || if_id_valid !== 1'b1 || if_id_pc_plus4 !== 32'h100) begin
      n_err++; $display("FAIL last_word_legal: fault=%b valid=%b pc4=%h expected 0/1/100",
                        fetch_fault, if_id_valid, if_id_pc_plus4);
    end
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (fetch_fault !== 1'b1 || if_id_valid !== 1'b0) begin
      n_err++; $display("FAIL past_end_fault: fault=%b valid=%b expected 1/0", fetch_fault, if_id_valid);
    end
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (pc !== 32'h0) begin
      n_err++; $display("FAIL pc_wrap: pc=%h expected 0", pc);
    end
  endtask

  task automatic test_random();
    logic st, br, jp;
    logic [31:0] bt, jt;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      st = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 9) == 0);
      jp = ($urandom_range(0, 9) == 0);
      bt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      jt = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      if (i > 45 && $urandom_range(0, 3) == 0) jt[0] = 1'b1;
      drive_and_score(st, br, bt, jp, jt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 7; i++) drive_and_score(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    n_vec++;
    if (pc !== 32'h1C) begin
      n_err++; $display("FAIL async_setup: pc=%h expected 1c", pc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (pc !== 32'h0 || if_id_valid !== 1'b0 || fetch_count !== 32'h0) begin
      n_err++; $display("FAIL async_reset: pc=%h valid=%b cnt=%0d expected 0/0/0",
                        pc, if_id_valid, fetch_count);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20; mem[1] = 8'h08; mem[2]  = 8'h00; mem[3]  = 8'h05;
    mem[4] = 8'h20; mem[5] = 8'h09; mem[6]  = 8'h00; mem[7]  = 8'h07;
    mem[8] = 8'h01; mem[9] = 8'h09; mem[10] = 8'h50; mem[11] = 8'h20;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_jump_fault();
    test_boundary();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline; sits directly upstream of the byte-addressed, big-endian instruction memory.
- Owns the program counter and drives the memory's 32-bit read address.
- Captures the returned 32-bit instruction into the IF/ID pipeline register for the decoder.
- Handles sequential fetch, branch/jump redirect, hazard stalls, and flushes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_BYTES, 256, instruction memory size in bytes; used for the fetch-fault check.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on a bubble (sll $0,$0,0).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- read_address  output  32  byte address to the instruction memory; equals pc.
- instruction  input  32  word returned combinationally by the instruction memory for read_address.
- stall  input  1  hazard unit request; holds PC and IF/ID.
- branch_taken  input  1  resolved branch from EX; redirect to branch_target.
- branch_target  input  32  branch destination byte address.
- jump  input  1  jump decoded in ID; redirect to jump_target.
- jump_target  input  32  jump destination byte address.
- pc  output  32  current fetch PC.
- if_id_instr  output  32  registered instruction for decode.
- if_id_pc_plus4  output  32  registered PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- fetch_fault  output  1  sticky: an illegal fetch address was seen.
- fetch_count  output  32  number of instructions latched into IF/ID with valid=1.

Behaviour:
- Reset (rst_n low, async): pc=RESET_PC; if_id_instr=NOP_WORD; if_id_pc_plus4=0; if_id_valid=0; fetch_fault=0; fetch_count=0. Outputs hold these values until the first rising edge after rst_n rises.
- read_address is combinational from pc; the memory returns instruction in the same cycle, so fetch latency is 1 cycle (PC → IF/ID).
- Next-PC priority per rising edge, highest first:
  1. branch_taken: pc←branch_target; IF/ID←bubble. Applies even when stall=1, because the branch belongs to an older instruction.
  2. jump: pc←jump_target; IF/ID←bubble. Ignored if stall=1, since the jump is still in ID and will be re-presented.
  3. stall: pc, IF/ID, and fetch_count hold.
  4. Otherwise: pc←pc+4; if_id_instr←instruction; if_id_pc_plus4←pc+4; if_id_valid←1; fetch_count+1.
- Bubble: if_id_instr=NOP_WORD, if_id_valid=0, if_id_pc_plus4 unchanged; fetch_count does not increment.
- branch_taken and jump in the same cycle: the branch wins and the jump is discarded.
- Arithmetic: pc+4 is 32-bit modulo (32'hFFFF_FFFC+4 → 0); fetch_count wraps at 2^32.
- Fault: a fetch is illegal if pc[1:0]≠0 or pc > IMEM_BYTES-4.
  - The check is evaluated on any cycle that would latch a valid instruction.
  - On an illegal fetch, fetch_fault←1 (sticky until reset) and a bubble is latched instead of the memory word.
  - pc still advances normally.
- Redirect targets are not checked at load; the fault appears on the following fetch.
- Reset asserted mid-operation aborts immediately to reset values; no partial update.
- No internal FSM beyond the PC/IF-ID registers; fault is a one-bit sticky state.

Decomposition:
- Shared package (mips_pkg): NOP_WORD, default RESET_PC, and a next-PC select enum {NPC_SEQ, NPC_BRANCH, NPC_JUMP, NPC_HOLD}.
- Natural sub-module: if_id_reg, the pipeline register with hold/flush controls, later reused by decode.
- The next-PC mux and fault check stay in fetch_stage.

Test Plan:
- Reset then free-run; memory bytes 0..11 = 20 08 00 05, 20 09 00 07, 01 09 50 20 → after 3 edges: pc=12, if_id_instr=32'h0109_5020, if_id_pc_plus4=12, fetch_count=3.
- stall=1 for 2 cycles at pc=8 → pc stays 8, IF/ID unchanged, fetch_count unchanged; on release, resumes at 8 with no skip or duplicate.
- branch_taken=1, branch_target=32'h40, with stall=1 → next edge: pc=64, if_id_valid=0, if_id_instr=0.
- branch_taken=1 (target 32'h20) and jump=1 (target 32'h80) together → pc=32; jump ignored.
- jump_target=32'h102 → next edge pc=32'h102; following edge fetch_fault=1, if_id_valid=0, pc=32'h106; fetch_fault stays 1 until rst_n pulses low.
- Assert rst_n low asynchronously between edges at pc=32'h1C → pc=0 and if_id_valid=0 immediately, without waiting for an edge.
